// File: rtl/parallax_scroll_scheduler.sv
// Per-frame parallax scroll controller: one shared adder advances every layer's position on vsync,
// then all offsets commit together. Define SCROLL_FRAC_EN for Q6.2 velocities and fractional positions.
module parallax_scroll_scheduler #(
    parameter int NUM_LAYERS = 5,
    parameter int POS_W      = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        vsync,
    input  logic                        pause,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [2:0]                  cfg_layer,
    input  logic [1:0]                  cfg_op,
    input  logic [7:0]                  cfg_vel,
    output logic [NUM_LAYERS*POS_W-1:0] off_x,
    output logic [NUM_LAYERS*POS_W-1:0] off_y,
    output logic [9:0]                  frame_cnt,
    output logic                        busy
);

`ifdef SCROLL_FRAC_EN
    localparam int FRAC = 2;
`else
    localparam int FRAC = 0;
`endif
    localparam int AW = POS_W + FRAC;
    localparam int KW = $clog2(2 * NUM_LAYERS);
    localparam logic [KW-1:0] K_LAST = KW'(2 * NUM_LAYERS - 1);

    typedef enum logic [1:0] {IDLE, UPD, COMMIT} state_t;

    state_t                      state_q;
    logic                        vsync_q;
    logic                        busy_q;
    logic                        commit_q;
    logic [KW-1:0]               k_q;
    logic [AW-1:0]               posX_q [NUM_LAYERS];
    logic [AW-1:0]               posY_q [NUM_LAYERS];
    logic [7:0]                  velX_q [NUM_LAYERS];
    logic [7:0]                  velY_q [NUM_LAYERS];
    logic [NUM_LAYERS*POS_W-1:0] offX_q;
    logic [NUM_LAYERS*POS_W-1:0] offY_q;
    logic [9:0]                  frameCnt_q;

    logic                        vsyncEdge;
    logic                        cfgAccept;
    logic [AW-1:0]               addA_d;
    logic [7:0]                  velSel_d;
    logic [AW-1:0]               sum_d;

    function automatic logic [7:0] defaultVel(input int layer, input logic yAxis);
        logic [7:0] v;
`ifdef SCROLL_FRAC_EN
        case (layer)
            0:       v = yAxis ? 8'd8 : 8'd64;
            1:       v = yAxis ? 8'd6 : 8'd28;
            2:       v = yAxis ? 8'd2 : 8'd16;
            3:       v = yAxis ? 8'd1 : 8'd8;
            4:       v = yAxis ? 8'd1 : 8'd2;
            default: v = 8'd0;
        endcase
`else
        case (layer)
            0:       v = yAxis ? 8'd2 : 8'd16;
            1:       v = yAxis ? 8'd1 : 8'd7;
            2:       v = yAxis ? 8'd0 : 8'd4;
            3:       v = yAxis ? 8'd0 : 8'd2;
            default: v = 8'd0;
        endcase
`endif
        return v;
    endfunction

    assign vsyncEdge = vsync & ~vsync_q;
    assign cfg_ready = (state_q == IDLE) & ~vsyncEdge;
    assign cfgAccept = cfg_valid & cfg_ready;

    // Step k selects layer k/2; even steps work on x, odd steps on y.
    always_comb begin
        addA_d   = '0;
        velSel_d = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (int'(k_q >> 1) == i) begin
                addA_d   = k_q[0] ? posY_q[i] : posX_q[i];
                velSel_d = k_q[0] ? velY_q[i] : velX_q[i];
            end
        end
        sum_d = addA_d + AW'($signed(velSel_d));
    end

    // Offsets land one cycle after COMMIT so they move together with busy falling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            vsync_q    <= 1'b0;
            busy_q     <= 1'b0;
            commit_q   <= 1'b0;
            k_q        <= '0;
            offX_q     <= '0;
            offY_q     <= '0;
            frameCnt_q <= '0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                posX_q[i] <= '0;
                posY_q[i] <= '0;
                velX_q[i] <= defaultVel(i, 1'b0);
                velY_q[i] <= defaultVel(i, 1'b1);
            end
        end else begin
            vsync_q  <= vsync;
            busy_q   <= (state_q != IDLE);
            commit_q <= 1'b0;
            if (commit_q) begin
                for (int i = 0; i < NUM_LAYERS; i++) begin
                    offX_q[i*POS_W +: POS_W] <= posX_q[i][AW-1 -: POS_W];
                    offY_q[i*POS_W +: POS_W] <= posY_q[i][AW-1 -: POS_W];
                end
                frameCnt_q <= frameCnt_q + 10'd1;
            end
            case (state_q)
                IDLE: begin
                    if (vsyncEdge && !pause) begin
                        state_q <= UPD;
                        k_q     <= '0;
                    end else if (cfgAccept) begin
                        for (int i = 0; i < NUM_LAYERS; i++) begin
                            if (cfg_layer == 3'(i)) begin
                                case (cfg_op)
                                    2'b00: velX_q[i] <= cfg_vel;
                                    2'b01: velY_q[i] <= cfg_vel;
                                    2'b10: begin
                                        posX_q[i] <= '0;
                                        posY_q[i] <= '0;
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    end
                end
                UPD: begin
                    for (int i = 0; i < NUM_LAYERS; i++) begin
                        if (int'(k_q >> 1) == i) begin
                            if (k_q[0]) posY_q[i] <= sum_d;
                            else        posX_q[i] <= sum_d;
                        end
                    end
                    if (k_q == K_LAST) state_q <= COMMIT;
                    else               k_q     <= k_q + KW'(1);
                end
                COMMIT: begin
                    state_q  <= IDLE;
                    commit_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign off_x     = offX_q;
    assign off_y     = offY_q;
    assign frame_cnt = frameCnt_q;

endmodule
